// File: rtl/ft_sync_bridge.sv
// ft_sync_bridge: FT245-style synchronous FIFO bridge between the device bus and two byte streams.
// Optional feature: define FT_STATS_EN to add 32-bit rx_count/tx_count bus byte counters.

module ft_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                   clkout,
    input  logic                   rdreset,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // The extra pointer bit tells full (indices equal, wrap bits differ) from empty.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign level   = wr_ptr - rd_ptr;
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clkout) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

    always_ff @(posedge clkout or posedge rdreset) begin
        if (rdreset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
        end
    end
endmodule

module ft_sync_bridge #(
    parameter int WIDTH     = 8,
    parameter int RX_DEPTH  = 16,
    parameter int TX_DEPTH  = 16,
    parameter int BURST_MAX = 64
) (
    input  logic             clkout,
    input  logic             rdreset,
    input  logic             rxf_n,
    input  logic             txe_n,
    output logic             oe_n,
    output logic             rd_n,
    output logic             wr_n,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic             data_oe,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    input  logic             rx_ready,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready
`ifdef FT_STATS_EN
    ,
    output logic [31:0]      rx_count,
    output logic [31:0]      tx_count
`endif
);
    localparam int RCW = $clog2(RX_DEPTH) + 1;
    localparam int TCW = $clog2(TX_DEPTH) + 1;
    localparam int BW  = $clog2(BURST_MAX + 1);
    localparam logic [RCW-1:0] RX_ENTRY_MAX = RCW'(RX_DEPTH - 2);
    localparam logic [RCW-1:0] RX_FULL_LVL  = RCW'(RX_DEPTH);
    localparam logic [BW-1:0]  BURST_LAST   = BW'(BURST_MAX - 1);

    typedef enum logic [2:0] {IDLE, PREP, READ, TURN, WRITE} state_t;

    state_t           state;
    logic             prefer_rx;
    logic             txe_prev;
    logic [BW-1:0]    burst_cnt;

    logic             rx_push, rx_pop, rx_full, rx_empty;
    logic             tx_push, tx_pop, tx_full, tx_empty;
    logic [RCW-1:0]   rx_level, rx_level_next;
    logic [TCW-1:0]   tx_level, tx_level_next;
    logic [WIDTH-1:0] tx_head;
    logic             rx_room_next;
    logic             rx_req, tx_req;

    assign rx_push  = !rd_n && !rxf_n && !rx_full;
    assign rx_pop   = rx_ready && !rx_empty;
    assign rx_valid = !rx_empty;
    assign tx_push  = tx_valid && !tx_full;
    assign tx_pop   = !wr_n && !txe_n && !tx_empty;
    assign tx_ready = !tx_full;

    // rd_n only stays low while the following edge is guaranteed a free slot.
    assign rx_level_next = rx_level + RCW'(rx_push) - RCW'(rx_pop);
    assign tx_level_next = tx_level + TCW'(tx_push) - TCW'(tx_pop);
    assign rx_room_next  = (rx_level_next < RX_FULL_LVL);
    assign rx_req        = !rxf_n && (rx_level <= RX_ENTRY_MAX);
    assign tx_req        = !txe_n && !tx_empty;
    assign data_o        = data_oe ? tx_head : '0;

    ft_sync_fifo #(.WIDTH(WIDTH), .DEPTH(RX_DEPTH)) rx_fifo (
        .clkout(clkout), .rdreset(rdreset),
        .push(rx_push), .push_data(data_i), .pop(rx_pop),
        .head(rx_data), .full(rx_full), .empty(rx_empty), .level(rx_level)
    );

    ft_sync_fifo #(.WIDTH(WIDTH), .DEPTH(TX_DEPTH)) tx_fifo (
        .clkout(clkout), .rdreset(rdreset),
        .push(tx_push), .push_data(tx_data), .pop(tx_pop),
        .head(tx_head), .full(tx_full), .empty(tx_empty), .level(tx_level)
    );

    // Every burst exits through TURN, so oe_n and data_oe are never active together.
    always_ff @(posedge clkout or posedge rdreset) begin
        if (rdreset) begin
            state     <= IDLE;
            oe_n      <= 1'b1;
            rd_n      <= 1'b1;
            wr_n      <= 1'b1;
            data_oe   <= 1'b0;
            prefer_rx <= 1'b1;
            txe_prev  <= 1'b0;
            burst_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (rx_req && (prefer_rx || !tx_req)) begin
                        state     <= PREP;
                        oe_n      <= 1'b0;
                        burst_cnt <= '0;
                        prefer_rx <= 1'b0;
                    end else if (tx_req) begin
                        state     <= WRITE;
                        data_oe   <= 1'b1;
                        wr_n      <= 1'b0;
                        burst_cnt <= '0;
                        txe_prev  <= 1'b0;
                        prefer_rx <= 1'b1;
                    end
                end
                PREP: begin
                    state <= READ;
                    rd_n  <= !rx_room_next;
                end
                READ: begin
                    if (rx_push) burst_cnt <= burst_cnt + BW'(1);
                    if (rxf_n || !rx_room_next || (rx_push && burst_cnt == BURST_LAST)) begin
                        state <= TURN;
                        oe_n  <= 1'b1;
                        rd_n  <= 1'b1;
                    end else begin
                        rd_n  <= 1'b0;
                    end
                end
                WRITE: begin
                    txe_prev <= txe_n;
                    if (tx_pop) burst_cnt <= burst_cnt + BW'(1);
                    if ((tx_level_next == '0) || (txe_n && txe_prev) ||
                        (tx_pop && burst_cnt == BURST_LAST)) begin
                        state   <= TURN;
                        wr_n    <= 1'b1;
                        data_oe <= 1'b0;
                    end
                end
                TURN: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef FT_STATS_EN
    // Counts bytes actually moved across the device bus, wrapping naturally at 2^32.
    always_ff @(posedge clkout or posedge rdreset) begin
        if (rdreset) begin
            rx_count <= '0;
            tx_count <= '0;
        end else begin
            if (rx_push) rx_count <= rx_count + 32'd1;
            if (tx_pop)  tx_count <= tx_count + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_ft_sync_bridge.sv
// tb_ft_sync_bridge: directed self-checking bench for ft_sync_bridge.
// Instance a uses default parameters; instance b has a 4-entry RX buffer and 4-byte bursts.

module tb_ft_sync_bridge;
    localparam int W = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_a, rxf_n_a, txe_n_a, oe_n_a, rd_n_a, wr_n_a, data_oe_a;
    logic [W-1:0] data_i_a, data_o_a, rx_data_a, tx_data_a;
    logic         rx_valid_a, rx_ready_a, tx_valid_a, tx_ready_a;

    logic         rst_b, rxf_n_b, txe_n_b, oe_n_b, rd_n_b, wr_n_b, data_oe_b;
    logic [W-1:0] data_i_b, data_o_b, rx_data_b, tx_data_b;
    logic         rx_valid_b, rx_ready_b, tx_valid_b, tx_ready_b;
`ifdef FT_STATS_EN
    logic [31:0]  rx_count_a, tx_count_a, rx_count_b, tx_count_b;
`endif

    ft_sync_bridge #(.WIDTH(W), .RX_DEPTH(16), .TX_DEPTH(16), .BURST_MAX(64)) dut_a (
        .clkout(clk), .rdreset(rst_a), .rxf_n(rxf_n_a), .txe_n(txe_n_a),
        .oe_n(oe_n_a), .rd_n(rd_n_a), .wr_n(wr_n_a),
        .data_i(data_i_a), .data_o(data_o_a), .data_oe(data_oe_a),
        .rx_data(rx_data_a), .rx_valid(rx_valid_a), .rx_ready(rx_ready_a),
        .tx_data(tx_data_a), .tx_valid(tx_valid_a), .tx_ready(tx_ready_a)
`ifdef FT_STATS_EN
        , .rx_count(rx_count_a), .tx_count(tx_count_a)
`endif
    );

    ft_sync_bridge #(.WIDTH(W), .RX_DEPTH(4), .TX_DEPTH(16), .BURST_MAX(4)) dut_b (
        .clkout(clk), .rdreset(rst_b), .rxf_n(rxf_n_b), .txe_n(txe_n_b),
        .oe_n(oe_n_b), .rd_n(rd_n_b), .wr_n(wr_n_b),
        .data_i(data_i_b), .data_o(data_o_b), .data_oe(data_oe_b),
        .rx_data(rx_data_b), .rx_valid(rx_valid_b), .rx_ready(rx_ready_b),
        .tx_data(tx_data_b), .tx_valid(tx_valid_b), .tx_ready(tx_ready_b)
`ifdef FT_STATS_EN
        , .rx_count(rx_count_b), .tx_count(tx_count_b)
`endif
    );

    typedef struct {
        logic       rxf_n;
        logic [7:0] data_i;
        logic       oe_n;
        logic       rd_n;
        logic       rx_valid;
        logic [7:0] rx_data;
    } vec_t;

    vec_t       vecs[13];
    int         checks = 0;
    int         errors = 0;
    logic [7:0] host_q[$];
    logic [7:0] rxq[$];
    logic [7:0] stalled;
    logic       took, popped;
    int         dev_idx, stored, drops, overlap;
    byte        trace[26];
    string      exp_trace;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        rxf_n_a  = v.rxf_n;
        data_i_a = v.data_i;
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_a = 1'b1; rxf_n_a = 1'b1; txe_n_a = 1'b1; data_i_a = '0;
        rx_ready_a = 1'b1; tx_valid_a = 1'b0; tx_data_a = '0;
        rst_b = 1'b1; rxf_n_b = 1'b1; txe_n_b = 1'b1; data_i_b = '0;
        rx_ready_b = 1'b0; tx_valid_b = 1'b0; tx_data_b = '0;

        // rxf_n, data_i -> oe_n, rd_n, rx_valid, rx_data for the 8-byte read burst
        vecs[0]  = '{1'b0, 8'h01, 1'b0, 1'b1, 1'b0, 8'h00};
        vecs[1]  = '{1'b0, 8'h01, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[2]  = '{1'b0, 8'h01, 1'b0, 1'b0, 1'b1, 8'h01};
        vecs[3]  = '{1'b0, 8'h02, 1'b0, 1'b0, 1'b1, 8'h02};
        vecs[4]  = '{1'b0, 8'h03, 1'b0, 1'b0, 1'b1, 8'h03};
        vecs[5]  = '{1'b0, 8'h04, 1'b0, 1'b0, 1'b1, 8'h04};
        vecs[6]  = '{1'b0, 8'h05, 1'b0, 1'b0, 1'b1, 8'h05};
        vecs[7]  = '{1'b0, 8'h06, 1'b0, 1'b0, 1'b1, 8'h06};
        vecs[8]  = '{1'b0, 8'h07, 1'b0, 1'b0, 1'b1, 8'h07};
        vecs[9]  = '{1'b0, 8'h08, 1'b0, 1'b0, 1'b1, 8'h08};
        vecs[10] = '{1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00};
        vecs[11] = '{1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00};
        vecs[12] = '{1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00};
        exp_trace = "QPRRRRQQWWWWQQPRRRRQQWWWWQ";

        cycle();
        cycle();
        checkOutput("reset_a strobes", {oe_n_a, rd_n_a, wr_n_a, data_oe_a, rx_valid_a, tx_ready_a}, 6'b111001);
        checkOutput("reset_a data_o", data_o_a, 8'h00);
        checkOutput("reset_b strobes", {oe_n_b, rd_n_b, wr_n_b, data_oe_b, rx_valid_b, tx_ready_b}, 6'b111001);
        rst_a = 1'b0;
        rst_b = 1'b0;
        cycle();

        // Eight-byte read burst driven from the vector table.
        for (int i = 0; i < 13; i++) begin
            applyStimulus(vecs[i]);
            cycle();
            checkOutput($sformatf("vec%0d strobes", i),
                        {oe_n_a, rd_n_a, wr_n_a, data_oe_a, rx_valid_a},
                        {vecs[i].oe_n, vecs[i].rd_n, 1'b1, 1'b0, vecs[i].rx_valid});
            if (vecs[i].rx_valid)
                checkOutput($sformatf("vec%0d rx_data", i), rx_data_a, vecs[i].rx_data);
        end

        // Write burst with a single-cycle txe_n stall on the third byte.
        txe_n_a = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tx_valid_a = 1'b1;
            tx_data_a  = 8'hA0 + 8'(i);
            cycle();
        end
        tx_valid_a = 1'b0;
        stalled = 8'h00;
        for (int k = 0; k < 10; k++) begin
            txe_n_a = (k == 3) ? 1'b1 : 1'b0;
            if (k == 3) stalled = data_o_a;
            if (k == 4) begin
                checkOutput("stall data_oe held", data_oe_a, 1'b1);
                checkOutput("stall re-present", data_o_a, 8'hA2);
            end
            if (!wr_n_a && !txe_n_a && data_oe_a) host_q.push_back(data_o_a);
            cycle();
        end
        checkOutput("stalled byte", stalled, 8'hA2);
        checkOutput("host byte count", host_q.size(), 5);
        for (int i = 0; i < 5; i++)
            if (i < host_q.size())
                checkOutput($sformatf("host byte %0d", i), host_q[i], 8'hA0 + 8'(i));
        checkOutput("after write idle", {wr_n_a, data_oe_a}, 2'b10);

        // Reset asserted mid-cycle while in WRITE.
        txe_n_a = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tx_valid_a = 1'b1;
            tx_data_a  = 8'hC0 + 8'(i);
            cycle();
        end
        tx_valid_a = 1'b0;
        txe_n_a = 1'b0;
        cycle();
        cycle();
        checkOutput("pre-reset in write", {wr_n_a, data_oe_a}, 2'b01);
        #3;
        rst_a = 1'b1;
        #1;
        checkOutput("mid-reset strobes", {oe_n_a, rd_n_a, wr_n_a, data_oe_a}, 4'b1110);
        checkOutput("mid-reset data_o", data_o_a, 8'h00);
        checkOutput("mid-reset buffers", {rx_valid_a, tx_ready_a}, 2'b01);
        cycle();
        rst_a = 1'b0;
        for (int i = 0; i < 3; i++) cycle();
        checkOutput("post-reset idle", {oe_n_a, wr_n_a, data_oe_a, tx_ready_a}, 4'b1101);

        // RX_DEPTH=4 with a stalled consumer and ten bytes on offer.
        dev_idx = 0; stored = 0; drops = 0;
        rxf_n_b = 1'b0;
        data_i_b = 8'h10;
        for (int k = 0; k < 110; k++) begin
            if (k == 30) begin
                checkOutput("full bytes taken", dev_idx, 4);
                checkOutput("full rd_n high", rd_n_b, 1'b1);
                checkOutput("full rx_valid", rx_valid_b, 1'b1);
                rx_ready_b = 1'b1;
            end
            took   = !rd_n_b && !rxf_n_b;
            popped = rx_valid_b && rx_ready_b;
            if (took && stored == 4) drops++;
            if (popped) rxq.push_back(rx_data_b);
            cycle();
            if (took) begin
                dev_idx++;
                stored++;
            end
            if (popped) stored--;
            rxf_n_b  = (dev_idx < 10) ? 1'b0 : 1'b1;
            data_i_b = 8'h10 + 8'(dev_idx);
        end
        checkOutput("overflow drops", drops, 0);
        checkOutput("rx byte count", rxq.size(), 10);
        for (int i = 0; i < 10; i++)
            if (i < rxq.size())
                checkOutput($sformatf("rx byte %0d", i), rxq[i], 8'h10 + 8'(i));

        // Round-robin with both directions always ready and 4-byte bursts.
        rxf_n_b = 1'b1; txe_n_b = 1'b1; rx_ready_b = 1'b1;
        rst_b = 1'b1;
        cycle();
        rst_b = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tx_valid_b = 1'b1;
            tx_data_b  = 8'h50 + 8'(i);
            cycle();
        end
        tx_valid_b = 1'b0;
        data_i_b = 8'h77;
        rxf_n_b = 1'b0;
        txe_n_b = 1'b0;
        overlap = 0;
        for (int k = 0; k < 26; k++) begin
            if (!rd_n_b && !rxf_n_b)                  trace[k] = "R";
            else if (!oe_n_b)                         trace[k] = "P";
            else if (data_oe_b && !wr_n_b && !txe_n_b) trace[k] = "W";
            else if (data_oe_b)                       trace[k] = "S";
            else                                      trace[k] = "Q";
            if (!oe_n_b && data_oe_b) overlap++;
            cycle();
        end
        for (int k = 0; k < 26; k++)
            checkOutput($sformatf("arb cycle %0d", k), trace[k], exp_trace[k]);
        checkOutput("oe/data_oe overlap", overlap, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end
endmodule
